// File: rtl/div_pkg.sv
// Shared constants for the EX-stage divider: FSM state encoding and result-valid levels.
package div_pkg;

    localparam logic [1:0] DIV_IDLE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {remainder, dividend/quotient} register.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W:0]   partial,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W:0]   step_c
);

    // Partial remainder with the next dividend bit appended, minus the divisor; MSB is the borrow.
    logic [DATA_W+1:0] diff;
    logic              unused_diff_msb;

    assign diff = {1'b0, partial[2*DATA_W:DATA_W]} - {2'b00, divisor};

    // A successful subtract always leaves diff below the divisor, so diff[DATA_W] is zero.
    assign unused_diff_msb = diff[DATA_W];

    always_comb begin
        if (diff[DATA_W+1]) begin
            step_c = {partial[2*DATA_W-1:0], 1'b0};
        end else begin
            step_c = {diff[DATA_W-1:0], partial[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for EX, one quotient bit per clock; result = {remainder, quotient}.
// DIV_SIGNED_EN enables signed division via signed_i; otherwise every division is unsigned.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int unsigned REG_W = 2 * DATA_W + 1;

    logic [1:0]          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [REG_W-1:0]    part, part_nxt, step_c;
    logic [DATA_W-1:0]   dvsr, dvsr_nxt;
    logic [2*DATA_W-1:0] result_nxt;
    logic                ready_nxt;
    logic [DATA_W-1:0]   dividend_abs, divisor_abs;
    logic [DATA_W-1:0]   quot, rem, quot_fix, rem_fix;

    assign quot = part[DATA_W-1:0];
    assign rem  = part[REG_W-1:DATA_W+1];

`ifdef DIV_SIGNED_EN
    logic neg_a, neg_b;
    logic neg_q, neg_q_nxt, neg_r, neg_r_nxt;

    // Magnitudes in; the most-negative value maps onto its own unsigned magnitude.
    assign neg_a        = signed_i & opdata1_i[DATA_W-1];
    assign neg_b        = signed_i & opdata2_i[DATA_W-1];
    assign dividend_abs = neg_a ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    assign divisor_abs  = neg_b ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

    // Quotient negated on sign mismatch, remainder follows the dividend; MIN/-1 wraps naturally.
    assign quot_fix = neg_q ? (~quot + DATA_W'(1)) : quot;
    assign rem_fix  = neg_r ? (~rem + DATA_W'(1)) : rem;
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign dividend_abs  = opdata1_i;
    assign divisor_abs   = opdata2_i;
    assign quot_fix      = quot;
    assign rem_fix       = rem;
`endif

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .partial (part),
        .divisor (dvsr),
        .step_c  (step_c)
    );

    assign busy_o = start_i & ~ready_o & ~annul_i;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_IDLE;
            cnt      <= '0;
            part     <= '0;
            dvsr     <= '0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            part     <= part_nxt;
            dvsr     <= dvsr_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
`ifdef DIV_SIGNED_EN
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
`endif
        end
    end

    // Next-state and next-output logic; annul_i wins over every other transition.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        part_nxt   = part;
        dvsr_nxt   = dvsr;
        result_nxt = result_o;
        ready_nxt  = ready_o;
`ifdef DIV_SIGNED_EN
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
`endif

        case (state)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_nxt = DIV_BYZERO;
                    end else begin
                        state_nxt = DIV_ON;
                        cnt_nxt   = '0;
                        part_nxt  = {{DATA_W{1'b0}}, dividend_abs, 1'b0};
                        dvsr_nxt  = divisor_abs;
`ifdef DIV_SIGNED_EN
                        neg_q_nxt = neg_a ^ neg_b;
                        neg_r_nxt = neg_a;
`endif
                    end
                end
            end

            DIV_BYZERO: begin
                if (annul_i) begin
                    state_nxt = DIV_IDLE;
                end else begin
                    state_nxt  = DIV_END;
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_READY;
                end
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_nxt = DIV_IDLE;
                end else if (cnt != CNT_W'(DATA_W)) begin
                    part_nxt = step_c;
                    cnt_nxt  = cnt + CNT_W'(1);
                end else begin
                    state_nxt  = DIV_END;
                    result_nxt = {rem_fix, quot_fix};
                    ready_nxt  = DIV_RESULT_READY;
                end
            end

            default: begin
                if (!start_i) begin
                    state_nxt  = DIV_IDLE;
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit at DATA_W = 32 (signed cases follow DIV_SIGNED_EN).
module tb_div_unit;

    localparam int unsigned DATA_W = 32;

    logic                clk;
    logic                rst;
    logic                start_i;
    logic                annul_i;
    logic                signed_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o;
    logic                busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full handshake: raise start, wait for ready, hold a cycle, release, see END -> IDLE.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp, input int exp_lat);
        int  edges;
        bit  done;
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        #1 check({tag, ".busy_start"}, 64'(busy_o), 64'd1);
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            // Operands are latched at the first edge; later changes must not matter.
            if (edges == 1) begin
                opdata1_i = ~a;
                opdata2_i = 32'h0000_0001;
            end
            if (ready_o) done = 1'b1;
        end
        check({tag, ".latency"}, 64'(edges - 1), 64'(exp_lat));
        check({tag, ".result"}, result_o, exp);
        check({tag, ".busy_ready"}, 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;
        check({tag, ".hold_ready"}, 64'(ready_o), 64'd1);
        check({tag, ".hold_result"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".idle_ready"}, 64'(ready_o), 64'd0);
        check({tag, ".idle_result"}, result_o, 64'd0);
        @(posedge clk);
    endtask

    initial begin
        int seen_ready;
        rst       = 1'b1;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        #2 rst = 1'b0;
        #1;
        check("reset.result", result_o, 64'd0);
        check("reset.ready", 64'(ready_o), 64'd0);
        check("reset.busy", 64'(busy_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
        run_div("div0", 32'd5, 32'd0, 1'b0, 64'd0, 1);
        run_div("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, 33);
        run_div("u_max_16", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 64'h0000000F_0FFFFFFF, 33);
        run_div("u_max_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h00000000_FFFFFFFF, 33);
        run_div("u_small", 32'd3, 32'd10, 1'b0, 64'h00000003_00000000, 33);
`ifdef DIV_SIGNED_EN
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33);
        run_div("s_m8_m3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 64'hFFFFFFFE_00000002, 33);
`else
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'h00000001_7FFFFFFC, 33);
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000007_00000000, 33);
        run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h80000000_00000000, 33);
`endif

        // Annul at iteration 10: the operation is dropped and ready never rises.
        @(negedge clk);
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1 check("annul.busy", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1 check("annul.ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen_ready = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen_ready++;
        end
        check("annul.never_ready", 64'(seen_ready), 64'd0);
        check("annul.result", result_o, 64'd0);
        run_div("after_annul", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

        // Asynchronous reset at iteration 20 clears everything without a clock edge.
        @(negedge clk);
        start_i   = 1'b1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (21) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("rst_mid.result", result_o, 64'd0);
        check("rst_mid.ready", 64'(ready_o), 64'd0);
        check("rst_mid.busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div("after_rst", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);

        // Asynchronous reset while holding a finished result in END.
        @(negedge clk);
        start_i   = 1'b1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (34) @(posedge clk);
        #1 check("rst_end.pre_ready", 64'(ready_o), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_end.result", result_o, 64'd0);
        check("rst_end.ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        run_div("after_rst_end", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
